// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset controller.
// States, opcodes, ALU/immediate codes and datapath select values live here.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_JALR, S_JAL, S_BRANCH, S_LUI, S_TRAP
    } state_t;

    typedef enum logic [1:0] {CLS_ADD, CLS_SUB, CLS_R, CLS_I} alu_class_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RD1   = 2'b10;
    localparam logic [1:0] SRC_B_RD2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;
    localparam logic [1:0] RES_IMM     = 2'b11;

    // States that sit on the shared memory and are guarded by the watchdog.
    function automatic logic is_wait_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps the current state class and funct fields onto an ALU operation.
// o_funct_ok flags funct3 values the ALU-type instructions support.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_class_t i_class,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control,
    output logic       o_funct_ok
);

    logic [2:0] w_funct_op;

    always_comb begin
        w_funct_op = ALU_ADD;
        o_funct_ok = 1'b1;
        case (i_funct3)
            3'b000:  w_funct_op = (i_class == CLS_R && i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  w_funct_op = ALU_SLT;
            3'b100:  w_funct_op = ALU_XOR;
            3'b110:  w_funct_op = ALU_OR;
            3'b111:  w_funct_op = ALU_AND;
            default: o_funct_ok = 1'b0;
        endcase

        case (i_class)
            CLS_SUB: o_alu_control = ALU_SUB;
            CLS_R,
            CLS_I:   o_alu_control = w_funct_op;
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32I-subset datapath with shared memory.
// Traps on illegal encodings and on a stalled memory access (watchdog).
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    input  logic       i_zero,
    input  logic       i_lt,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_write,
    output logic       o_adr_src,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [2:0] o_alu_control,
    output logic [2:0] o_imm_src,
    output logic [1:0] o_result_src,
    output logic       o_reg_write,
    output logic       o_instr_done,
    output logic       o_illegal
);

    state_t          r_state, w_next;
    logic [TW-1:0]   r_wait;
    alu_class_t      w_class;
    logic [2:0]      w_dec_alu;
    logic            w_funct_ok;
    logic            w_timeout;
    logic            w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write;
    logic            w_reg_write, w_instr_done, w_illegal;
    logic [1:0]      w_src_a, w_src_b, w_result_src;
    logic [2:0]      w_alu, w_imm;

    assign w_class = (r_state == S_EXECR)  ? CLS_R :
                     (r_state == S_EXECI)  ? CLS_I :
                     (r_state == S_BRANCH) ? CLS_SUB : CLS_ADD;

    mc_alu_decoder u_alu_decoder (
        .i_class       (w_class),
        .i_funct3      (i_funct3),
        .i_funct7b5    (i_funct7[5]),
        .o_alu_control (w_dec_alu),
        .o_funct_ok    (w_funct_ok)
    );

    // The access that would be the TIMEOUT-th stalled cycle traps instead.
    assign w_timeout = (TIMEOUT != 0) && !i_mem_ready && (r_wait == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_next == r_state && is_wait_state(r_state)) ? r_wait + 1'b1 : '0;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_instr_done = 1'b0;
        w_illegal    = 1'b0;
        w_src_a      = SRC_A_PC;
        w_src_b      = SRC_B_RD2;
        w_result_src = RES_ALUOUT;
        w_alu        = ALU_ADD;
        w_imm        = IMM_I;
        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_src_b      = SRC_B_FOUR;
                w_result_src = RES_ALURES;
                w_ir_write   = i_mem_ready;
                w_pc_write   = i_mem_ready;
                w_next       = i_mem_ready ? S_DECODE : (w_timeout ? S_TRAP : S_FETCH);
            end
            S_DECODE: begin
                w_src_a = SRC_A_OLDPC;
                w_src_b = SRC_B_IMM;
                w_imm   = (i_opcode == OP_JAL) ? IMM_J : IMM_B;
                case (i_opcode)
                    OP_R:        w_next = w_funct_ok ? S_EXECR : S_TRAP;
                    OP_I:        w_next = w_funct_ok ? S_EXECI : S_TRAP;
                    OP_LW,
                    OP_SW:       w_next = (i_funct3 == 3'b010) ? S_MEMADR : S_TRAP;
                    OP_BR:       w_next = (i_funct3[1] == 1'b0) ? S_BRANCH : S_TRAP;
                    OP_JAL:      w_next = S_JAL;
                    OP_JALR:     w_next = (i_funct3 == 3'b000) ? S_JALR : S_TRAP;
                    OP_LUI:      w_next = S_LUI;
                    default:     w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                w_src_a = SRC_A_RD1;
                w_src_b = SRC_B_IMM;
                w_imm   = (i_opcode == OP_SW) ? IMM_S : IMM_I;
                w_next  = (i_opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                w_next    = i_mem_ready ? S_MEMWB : (w_timeout ? S_TRAP : S_MEMREAD);
            end
            S_MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req    = 1'b1;
                w_mem_write  = 1'b1;
                w_adr_src    = 1'b1;
                w_instr_done = i_mem_ready;
                w_next       = i_mem_ready ? S_FETCH : (w_timeout ? S_TRAP : S_MEMWRITE);
            end
            S_EXECR: begin
                w_src_a = SRC_A_RD1;
                w_alu   = w_dec_alu;
                w_next  = S_ALUWB;
            end
            S_EXECI: begin
                w_src_a = SRC_A_RD1;
                w_src_b = SRC_B_IMM;
                w_alu   = w_dec_alu;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_JALR: begin
                w_src_a = SRC_A_RD1;
                w_src_b = SRC_B_IMM;
                w_next  = S_JAL;
            end
            S_JAL: begin
                w_src_a    = SRC_A_OLDPC;
                w_src_b    = SRC_B_FOUR;
                w_pc_write = 1'b1;
                w_next     = S_ALUWB;
            end
            S_BRANCH: begin
                // funct3[2] selects the lt compare, funct3[0] inverts the condition.
                w_src_a      = SRC_A_RD1;
                w_alu        = w_dec_alu;
                w_instr_done = 1'b1;
                w_pc_write   = (i_funct3[2] ? i_lt : i_zero) ^ i_funct3[0];
                w_next       = S_FETCH;
            end
            S_LUI: begin
                w_imm        = IMM_U;
                w_result_src = RES_IMM;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_TRAP: begin
                w_illegal = 1'b1;
            end
            default: w_next = S_TRAP;
        endcase
    end

    // Reset gates every output combinationally so no strobe outlives rst_n falling.
    assign o_mem_req     = w_mem_req    & rst_n;
    assign o_mem_write   = w_mem_write  & rst_n;
    assign o_adr_src     = w_adr_src    & rst_n;
    assign o_ir_write    = w_ir_write   & rst_n;
    assign o_pc_write    = w_pc_write   & rst_n;
    assign o_reg_write   = w_reg_write  & rst_n;
    assign o_instr_done  = w_instr_done & rst_n;
    assign o_illegal     = w_illegal    & rst_n;
    assign o_alu_src_a   = rst_n ? w_src_a      : SRC_A_PC;
    assign o_alu_src_b   = rst_n ? w_src_b      : SRC_B_RD2;
    assign o_alu_control = rst_n ? w_alu        : ALU_ADD;
    assign o_imm_src     = rst_n ? w_imm        : IMM_I;
    assign o_result_src  = rst_n ? w_result_src : RES_ALUOUT;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller.
// A step-list model built from the instruction rules predicts every output each cycle.
module tb_multicycle_controller;

    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic       memReq, memWrite, adrSrc, irWrite, pcWrite;
        logic [1:0] srcA, srcB;
        logic [2:0] alu, imm;
        logic [1:0] res;
        logic       regWrite, done, illegal;
    } outVec_t;

    typedef enum int {
        stFetch, stDecode, stMemAdr, stMemRead, stMemWb, stMemWrite, stExecR,
        stExecI, stAluWb, stJalr, stJal, stBranch, stLui, stTrap
    } step_t;

    typedef struct {
        step_t step;
        bit    ready;
    } stepEnt_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       zero = 1'b0, lt = 1'b0, memReady = 1'b0;
    outVec_t    obs;

    stepEnt_t   plan[$];
    bit         planTraps;
    int         checks = 0;
    int         passes = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.TIMEOUT(TIMEOUT), .TW(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_opcode      (opcode),
        .i_funct3      (funct3),
        .i_funct7      (funct7),
        .i_zero        (zero),
        .i_lt          (lt),
        .i_mem_ready   (memReady),
        .o_mem_req     (obs.memReq),
        .o_mem_write   (obs.memWrite),
        .o_adr_src     (obs.adrSrc),
        .o_ir_write    (obs.irWrite),
        .o_pc_write    (obs.pcWrite),
        .o_alu_src_a   (obs.srcA),
        .o_alu_src_b   (obs.srcB),
        .o_alu_control (obs.alu),
        .o_imm_src     (obs.imm),
        .o_result_src  (obs.res),
        .o_reg_write   (obs.regWrite),
        .o_instr_done  (obs.done),
        .o_illegal     (obs.illegal)
    );

    task automatic checkOutput(input string tag, input logic [19:0] got, input logic [19:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    function automatic logic [2:0] aluFor(input logic [2:0] f3, input logic subBit);
        case (f3)
            3'b000:  return subBit ? 3'b001 : 3'b000;
            3'b010:  return 3'b100;
            3'b100:  return 3'b101;
            3'b110:  return 3'b011;
            default: return 3'b010;
        endcase
    endfunction

    function automatic bit isLegal();
        case (opcode)
            7'b0110011, 7'b0010011: return funct3 inside {3'd0, 3'd2, 3'd4, 3'd6, 3'd7};
            7'b0000011, 7'b0100011: return funct3 == 3'd2;
            7'b1100011:             return funct3 inside {3'd0, 3'd1, 3'd4, 3'd5};
            7'b1100111:             return funct3 == 3'd0;
            7'b1101111, 7'b0110111: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic outVec_t expectedOut(input step_t step, input bit ready);
        outVec_t v = '0;
        case (step)
            stFetch:    begin v.memReq = 1; v.srcB = 2'b10; v.res = 2'b10;
                              v.irWrite = ready; v.pcWrite = ready; end
            stDecode:   begin v.srcA = 2'b01; v.srcB = 2'b01;
                              v.imm = (opcode == 7'b1101111) ? 3'b011 : 3'b010; end
            stMemAdr:   begin v.srcA = 2'b10; v.srcB = 2'b01;
                              v.imm = (opcode == 7'b0100011) ? 3'b001 : 3'b000; end
            stMemRead:  begin v.memReq = 1; v.adrSrc = 1; end
            stMemWb:    begin v.res = 2'b01; v.regWrite = 1; v.done = 1; end
            stMemWrite: begin v.memReq = 1; v.memWrite = 1; v.adrSrc = 1; v.done = ready; end
            stExecR:    begin v.srcA = 2'b10; v.alu = aluFor(funct3, funct7[5]); end
            stExecI:    begin v.srcA = 2'b10; v.srcB = 2'b01; v.alu = aluFor(funct3, 1'b0); end
            stAluWb:    begin v.regWrite = 1; v.done = 1; end
            stJalr:     begin v.srcA = 2'b10; v.srcB = 2'b01; end
            stJal:      begin v.srcA = 2'b01; v.srcB = 2'b10; v.pcWrite = 1; end
            stBranch: begin
                v.srcA = 2'b10; v.alu = 3'b001; v.done = 1;
                case (funct3)
                    3'b000:  v.pcWrite = zero;
                    3'b001:  v.pcWrite = !zero;
                    3'b100:  v.pcWrite = lt;
                    default: v.pcWrite = !lt;
                endcase
            end
            stLui:      begin v.imm = 3'b100; v.res = 2'b11; v.regWrite = 1; v.done = 1; end
            default:    v.illegal = 1;
        endcase
        return v;
    endfunction

    task automatic pushStep(input step_t s);
        stepEnt_t e;
        e.step = s;
        e.ready = 1'($urandom_range(0, 1));
        plan.push_back(e);
    endtask

    // A memory step stalls 'waits' cycles; TIMEOUT stalled cycles end in the trap.
    task automatic addMem(input step_t s, input int waits);
        stepEnt_t e;
        e.step = s;
        e.ready = 1'b0;
        for (int k = 0; k < waits && k < TIMEOUT; k++) plan.push_back(e);
        if (waits >= TIMEOUT) begin
            planTraps = 1;
            for (int k = 0; k < 3; k++) pushStep(stTrap);
        end else begin
            e.ready = 1'b1;
            plan.push_back(e);
        end
    endtask

    task automatic buildPlan(input int fetchWaits, input int memWaits);
        plan.delete();
        planTraps = 0;
        addMem(stFetch, fetchWaits);
        if (planTraps) return;
        pushStep(stDecode);
        if (!isLegal()) begin
            planTraps = 1;
            for (int k = 0; k < 3; k++) pushStep(stTrap);
            return;
        end
        case (opcode)
            7'b0110011: begin pushStep(stExecR); pushStep(stAluWb); end
            7'b0010011: begin pushStep(stExecI); pushStep(stAluWb); end
            7'b0000011: begin
                pushStep(stMemAdr);
                addMem(stMemRead, memWaits);
                if (!planTraps) pushStep(stMemWb);
            end
            7'b0100011: begin pushStep(stMemAdr); addMem(stMemWrite, memWaits); end
            7'b1100011: pushStep(stBranch);
            7'b1101111: begin pushStep(stJal); pushStep(stAluWb); end
            7'b1100111: begin pushStep(stJalr); pushStep(stJal); pushStep(stAluWb); end
            default:    pushStep(stLui);
        endcase
    endtask

    task automatic applyStimulus();
        foreach (plan[i]) begin
            memReady = plan[i].ready;
            @(negedge clk);
            checkOutput($sformatf("op%b_f%b_%s_c%0d", opcode, funct3, plan[i].step.name(), i),
                        obs, expectedOut(plan[i].step, plan[i].ready));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #1;
        checkOutput(tag, obs, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic z, input logic l, input int fw, input int mw);
        opcode = op; funct3 = f3; funct7 = f7; zero = z; lt = l;
        buildPlan(fw, mw);
        applyStimulus();
        if (planTraps) doReset("resetAfterTrap");
    endtask

    initial begin
        logic [6:0] ops [8];
        logic [2:0] f3;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
        #3;
        checkOutput("resetInitial", obs, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        runInstr(7'b0110011, 3'b000, 7'b0000000, 0, 0, 0, 0);
        runInstr(7'b0110011, 3'b000, 7'b0100000, 0, 0, 0, 0);
        runInstr(7'b0000011, 3'b010, 7'b0000000, 0, 0, 0, 2);
        runInstr(7'b1100011, 3'b000, 7'b0000000, 1, 0, 0, 0);
        runInstr(7'b1100011, 3'b000, 7'b0000000, 0, 1, 0, 0);
        runInstr(7'b1100011, 3'b101, 7'b0000000, 1, 0, 0, 0);
        runInstr(7'b1100111, 3'b000, 7'b0000000, 0, 0, 1, 0);
        runInstr(7'b0110111, 3'b011, 7'b0000000, 0, 0, TIMEOUT - 1, 0);
        runInstr(7'b1111111, 3'b000, 7'b0000000, 0, 0, 0, 0);
        runInstr(7'b0110111, 3'b000, 7'b0000000, 0, 0, TIMEOUT + 4, 0);
        runInstr(7'b0000011, 3'b010, 7'b0000000, 0, 0, 0, TIMEOUT);
        runInstr(7'b0100011, 3'b010, 7'b0000000, 0, 0, 0, TIMEOUT - 1);

        // Abort a stalled store: the strobe must drop the moment rst_n falls.
        opcode = 7'b0100011; funct3 = 3'b010;
        buildPlan(0, 3);
        while (plan.size() > 4) void'(plan.pop_back());
        applyStimulus();
        memReady = 1'b0;
        #2;
        checkOutput("storeStrobeHeld", 20'(obs.memWrite), 20'd1);
        doReset("storeStrobeDrop");
        runInstr(7'b0110111, 3'b000, 7'b0000000, 0, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            f3 = 3'($urandom);
            if ($urandom_range(0, 5) != 0) begin
                case (op)
                    7'b0000011, 7'b0100011: f3 = 3'b010;
                    7'b1100111:             f3 = 3'b000;
                    7'b1100011:             f3 = {f3[2], 1'b0, f3[0]};
                    default: if (f3 inside {3'd1, 3'd3, 3'd5}) f3 = 3'b000;
                endcase
            end
            runInstr(op, f3, 7'($urandom), 1'($urandom), 1'($urandom),
                     $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
